// File: rtl/core_data_mem_responder.sv
// ---------------------------------------------------------------------------
// core_data_mem_responder
//   Memory-side responder for the execution unit's load/store port. Accepts
//   one byte/halfword/word request at a time, services it from an internal
//   byte-addressed array of 32-bit words after WAIT_STATES extra cycles, and
//   returns read data plus a misalignment/reserved-size error flag.
//
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     req_valid_i      request present
//     req_ready_o      responder idle and able to accept a request
//     req_we_i         1 = store, 0 = load
//     req_size_i       00 byte, 01 half, 10 word, 11 reserved (error)
//     req_addr_i       byte address
//     req_wdata_i      store data, right-aligned
//     rsp_valid_o      response present
//     rsp_ready_i      core accepts response
//     rsp_rdata_o      load data, right-aligned, zero-extended
//     rsp_err_o        misaligned access or reserved size
// ---------------------------------------------------------------------------
module core_data_mem_responder #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int WAIT_STATES    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [1:0]                req_size_i,
  input  logic [MEM_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                      rsp_err_o
);

  localparam int WORDS = 1 << (MEM_ADDR_WIDTH - 2);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]                state;
  logic [3:0]                wait_cnt;
  logic                      we_q;
  logic [1:0]                size_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;

  logic [DATA_WIDTH-1:0]     mem [WORDS];

  logic [MEM_ADDR_WIDTH-3:0] word_idx;
  logic [4:0]                shift;
  logic                      misalign;
  logic [DATA_WIDTH-1:0]     size_mask;
  logic [DATA_WIDTH-1:0]     lane_mask;
  logic [DATA_WIDTH-1:0]     wdata_sh;
  logic [DATA_WIDTH-1:0]     rd_word;
  logic [DATA_WIDTH-1:0]     load_data;

  // Ready is gated by rst so no handshake can appear during a reset cycle.
  assign req_ready_o = (state == S_IDLE) && !rst;

  // Lane selection works on a whole word: the addressed lanes are found by
  // shifting a size mask to the byte offset, for both read and write.
  always_comb begin
    word_idx = addr_q[MEM_ADDR_WIDTH-1:2];
    shift    = {addr_q[1:0], 3'b000};
    misalign = 1'b0;
    unique case (size_q)
      2'b00: size_mask = DATA_WIDTH'(32'h0000_00FF);
      2'b01: begin
        size_mask = DATA_WIDTH'(32'h0000_FFFF);
        misalign  = addr_q[0];
      end
      2'b10: begin
        size_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        misalign  = |addr_q[1:0];
      end
      default: begin
        size_mask = '0;
        misalign  = 1'b1;
      end
    endcase
    lane_mask = size_mask << shift;
    wdata_sh  = wdata_q << shift;
    rd_word   = mem[word_idx];
    load_data = (rd_word >> shift) & size_mask;
  end

  // Array write happens only in COMMIT; gating on rst keeps a store that is
  // reset in its commit cycle from ever reaching the array.
  always_ff @(posedge clk) begin
    if (!rst && state == S_COMMIT && we_q && !misalign) begin
      mem[word_idx] <= (rd_word & ~lane_mask) | (wdata_sh & lane_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q     <= req_we_i;
            size_q   <= req_size_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            wait_cnt <= WAIT_LOAD;
            state    <= (WAIT_STATES > 0) ? S_WAIT : S_COMMIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_COMMIT;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_COMMIT: begin
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= misalign;
          rsp_rdata_o <= (misalign || we_q) ? '0 : load_data;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
